// File: rtl/btn_conditioner_if.sv
// Button conditioner bus: raw button in, conditioned level and strobes out.
// The master side drives the raw button; the slave side is the conditioner itself.
interface btn_conditioner_if;
  logic i_btn;
  logic o_level;
  logic o_press;
  logic o_release;
  logic o_long;
  logic o_repeat;
  logic o_toggle;

  modport master (output i_btn,
                  input  o_level, o_press, o_release, o_long, o_repeat, o_toggle);
  modport slave  (input  i_btn,
                  output o_level, o_press, o_release, o_long, o_repeat, o_toggle);
endinterface

// File: rtl/btn_conditioner.sv
// Push-button conditioner: 2-FF sync, debounce, press/release strobes, long-press FSM.
// Define BTN_AUTOREPEAT_EN to build the RPT state and the auto-repeat strobe.
module btn_conditioner #(
  parameter int DB_CYCLES     = 120000,
  parameter int LONG_CYCLES   = 6000000,
  parameter int REPEAT_CYCLES = 1200000
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  btn_conditioner_if.slave   bus
);
  localparam int MAX_A = (DB_CYCLES > LONG_CYCLES) ? DB_CYCLES : LONG_CYCLES;
  localparam int MAX_C = (MAX_A > REPEAT_CYCLES) ? MAX_A : REPEAT_CYCLES;
  localparam int CW    = $clog2(MAX_C) + 1;

`ifdef BTN_AUTOREPEAT_EN
  typedef enum logic [1:0] {IDLE, HOLD, RPT} state_t;
`else
  typedef enum logic [1:0] {IDLE, HOLD} state_t;
`endif

  logic          r_s1, r_s2;
  logic [CW-1:0] r_db_cnt;
  logic          r_level;
  logic          w_db_done, w_rise, w_fall;

  state_t        r_state;
  logic [CW-1:0] r_hold_cnt;
  logic          r_press, r_release, r_long, r_toggle;
`ifdef BTN_AUTOREPEAT_EN
  logic          r_repeat;
`else
  logic          r_long_done;
`endif

  // Level flips on the DB_CYCLES-th consecutive sample that disagrees with it.
  assign w_db_done = (r_s2 != r_level) && (r_db_cnt == CW'(DB_CYCLES - 1));
  assign w_rise    = w_db_done &&  r_s2;
  assign w_fall    = w_db_done && !r_s2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_db_cnt <= '0;
      r_level  <= 1'b0;
    end else begin
      r_s1 <= bus.i_btn;
      r_s2 <= r_s1;
      if (r_s2 == r_level) begin
        r_db_cnt <= '0;
      end else if (w_db_done) begin
        r_level  <= r_s2;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_hold_cnt <= '0;
      r_press    <= 1'b0;
      r_release  <= 1'b0;
      r_long     <= 1'b0;
      r_toggle   <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      r_repeat   <= 1'b0;
`else
      r_long_done <= 1'b0;
`endif
    end else begin
      r_press   <= w_rise;
      r_release <= w_fall;
      r_long    <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      r_repeat  <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
`ifndef BTN_AUTOREPEAT_EN
          r_long_done <= 1'b0;
`endif
          if (w_rise) begin
            r_state    <= HOLD;
            r_toggle   <= ~r_toggle;
            r_hold_cnt <= '0;
          end
        end
        // A release on the expiry cycle suppresses LONG/REPEAT.
        HOLD: begin
          if (w_fall) begin
            r_state <= IDLE;
`ifdef BTN_AUTOREPEAT_EN
          end else if (r_hold_cnt == CW'(LONG_CYCLES - 1)) begin
            r_long     <= 1'b1;
            r_state    <= RPT;
            r_hold_cnt <= '0;
`else
          end else if (r_long_done) begin
            r_hold_cnt <= r_hold_cnt;
          end else if (r_hold_cnt == CW'(LONG_CYCLES - 1)) begin
            r_long      <= 1'b1;
            r_long_done <= 1'b1;
`endif
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
`ifdef BTN_AUTOREPEAT_EN
        RPT: begin
          if (w_fall) begin
            r_state <= IDLE;
          end else if (r_hold_cnt == CW'(REPEAT_CYCLES - 1)) begin
            r_repeat   <= 1'b1;
            r_hold_cnt <= '0;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.o_level   = r_level;
  assign bus.o_press   = r_press;
  assign bus.o_release = r_release;
  assign bus.o_long    = r_long;
  assign bus.o_toggle  = r_toggle;
`ifdef BTN_AUTOREPEAT_EN
  assign bus.o_repeat  = r_repeat;
`else
  assign bus.o_repeat  = 1'b0;
`endif
endmodule
